// File: rtl/instr_sequencer.sv
// Instruction sequencer: a small FIFO feeds a two-state executor.
// The executor steps a 2-bit cycle counter and retires or aborts each instruction.
module instr_sequencer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned WD_LIMIT = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] instruction,
    output logic [1:0]  current_state,
    input  logic        clear_counter,
    output logic        busy,
    output logic        done,
    output logic [7:0]  retired_count,
    output logic        error
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned WDW = $clog2(WD_LIMIT + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    logic [0:0]     state;
    logic [0:0]     state_next;
    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [WDW-1:0] wd_count;

    logic full;
    logic empty;
    logic push;
    logic at_top;
    logic retire;
    logic timeout;
    logic finish;
    logic load;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign busy     = (state == EXEC);

    // Retirement and watchdog abort both end the instruction at counter 11.
    assign at_top  = (state == EXEC) && (current_state == 2'b11);
    assign retire  = at_top & clear_counter;
    assign timeout = at_top & ~clear_counter & (wd_count == WDW'(WD_LIMIT - 1));
    assign finish  = retire | timeout;
    assign load    = ~empty & ((state == IDLE) | finish);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!empty) state_next = EXEC;
            EXEC:    if (finish && empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Storage array carries no reset; occupancy is tracked by count.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_instr;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            instruction   <= '0;
            current_state <= 2'b00;
            wd_count      <= '0;
            done          <= 1'b0;
            retired_count <= '0;
            error         <= 1'b0;
        end else begin
            done <= retire;
            if (retire)  retired_count <= retired_count + 1'b1;
            if (timeout) error <= 1'b1;

            if (load) begin
                instruction   <= mem[rd_ptr];
                current_state <= 2'b00;
                wd_count      <= '0;
            end else if (finish) begin
                current_state <= 2'b00;
                wd_count      <= '0;
            end else if (state == EXEC) begin
                if (current_state != 2'b11) current_state <= current_state + 1'b1;
                else                        wd_count      <= wd_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: vector table, hand sequences and a load-order scoreboard.
module tb_instr_sequencer;

    logic        clock;
    logic        resetn;
    logic [15:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instruction;
    logic [1:0]  current_state;
    logic        clear_counter;
    logic        busy;
    logic        done;
    logic [7:0]  retired_count;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic        prev_busy;
    logic [1:0]  prev_cs;

    typedef struct {
        logic [15:0] instr;
        int          wait11;
        logic [7:0]  exp_count;
    } vec_t;

    vec_t vecs[4];

    instr_sequencer #(.DEPTH(4), .WD_LIMIT(8)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .in_instr      (in_instr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instruction   (instruction),
        .current_state (current_state),
        .clear_counter (clear_counter),
        .busy          (busy),
        .done          (done),
        .retired_count (retired_count),
        .error         (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cs(input logic [1:0] target);
        int n;
        n = 0;
        while (!(busy && current_state == target) && n < 60) begin
            step();
            n++;
        end
        check("wait_cs reached", 16'(n < 60), 16'd1);
    endtask

    task automatic push_word(input logic [15:0] w);
        in_instr = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_retire(input logic [15:0] w);
        wait_cs(2'b11);
        check("exec instruction", instruction, w);
        clear_counter = 1'b1;
        step();
        clear_counter = 1'b0;
        check("done pulse", 16'(done), 16'd1);
    endtask

    task automatic check_reset_values();
        check("rst instruction", instruction, 16'h0000);
        check("rst current_state", 16'(current_state), 16'd0);
        check("rst busy", 16'(busy), 16'd0);
        check("rst done", 16'(done), 16'd0);
        check("rst retired_count", 16'(retired_count), 16'd0);
        check("rst error", 16'(error), 16'd0);
        check("rst in_ready", 16'(in_ready), 16'd1);
    endtask

    // Scoreboard: record accepted words, compare each new load against the oldest.
    always @(negedge clock) begin
        if (!resetn) begin
            exp_q.delete();
            prev_busy = 1'b0;
            prev_cs   = 2'b00;
        end else begin
            if (busy && current_state == 2'b00 && !(prev_busy && prev_cs == 2'b00)) begin
                if (exp_q.size() == 0) check("unexpected load", instruction, 16'hxxxx);
                else check("load order", instruction, exp_q.pop_front());
            end
            prev_busy = busy;
            prev_cs   = current_state;
            if (in_valid && in_ready) exp_q.push_back(in_instr);
        end
    end

    initial begin
        int idx;
        logic was_ready;
        int n;

        vecs[0] = '{16'hA123, 0, 8'd2};
        vecs[1] = '{16'hB456, 3, 8'd3};
        vecs[2] = '{16'hC789, 7, 8'd4};
        vecs[3] = '{16'h1234, 1, 8'd5};

        resetn = 1'b0;
        in_instr = 16'h0000;
        in_valid = 1'b0;
        clear_counter = 1'b0;
        step();
        step();
        check_reset_values();
        resetn = 1'b1;
        step();

        // Single instruction walk through all counter values.
        push_word(16'h2000);
        check("idle before load", 16'(busy), 16'd0);
        step();
        check("load busy", 16'(busy), 16'd1);
        check("load cs", 16'(current_state), 16'd0);
        check("load instr", instruction, 16'h2000);
        step();
        check("cs 01", 16'(current_state), 16'd1);
        step();
        check("cs 10", 16'(current_state), 16'd2);
        step();
        check("cs 11", 16'(current_state), 16'd3);
        clear_counter = 1'b1;
        step();
        clear_counter = 1'b0;
        check("done after retire", 16'(done), 16'd1);
        check("count after retire", 16'(retired_count), 16'd1);
        check("idle after retire", 16'(busy), 16'd0);
        step();
        check("done single pulse", 16'(done), 16'd0);

        // Table: clear after a number of extra edges at 11 (7 is the watchdog boundary).
        for (int i = 0; i < 4; i++) begin
            push_word(vecs[i].instr);
            wait_cs(2'b11);
            for (int k = 0; k < vecs[i].wait11; k++) step();
            check("vec holding at 11", 16'(current_state), 16'd3);
            clear_counter = 1'b1;
            step();
            clear_counter = 1'b0;
            check("vec done", 16'(done), 16'd1);
            check("vec count", 16'(retired_count), 16'(vecs[i].exp_count));
            check("vec error", 16'(error), 16'd0);
            check("vec idle", 16'(busy), 16'd0);
        end

        // clear_counter at counter 01 has no effect.
        push_word(16'h4000);
        wait_cs(2'b01);
        clear_counter = 1'b1;
        step();
        clear_counter = 1'b0;
        check("early clear ignored cs", 16'(current_state), 16'd2);
        check("early clear no done", 16'(done), 16'd0);
        run_retire(16'h4000);
        check("count after early clear", 16'(retired_count), 16'd6);

        // Back-to-back execution with no idle gap.
        in_valid = 1'b1;
        in_instr = 16'hA001;
        step();
        in_instr = 16'hA402;
        step();
        in_instr = 16'hA803;
        step();
        in_valid = 1'b0;
        run_retire(16'hA001);
        check("b2b busy 1", 16'(busy), 16'd1);
        check("b2b cs 1", 16'(current_state), 16'd0);
        run_retire(16'hA402);
        check("b2b busy 2", 16'(busy), 16'd1);
        check("b2b cs 2", 16'(current_state), 16'd0);
        run_retire(16'hA803);
        check("b2b idle", 16'(busy), 16'd0);
        check("b2b count", 16'(retired_count), 16'd9);

        // Watchdog: eight edges at 11 without clear abort the instruction.
        push_word(16'h8000);
        wait_cs(2'b11);
        for (int k = 0; k < 7; k++) step();
        check("wd not yet", 16'(error), 16'd0);
        check("wd still busy", 16'(busy), 16'd1);
        step();
        check("wd error", 16'(error), 16'd1);
        check("wd idle", 16'(busy), 16'd0);
        check("wd no done", 16'(done), 16'd0);
        check("wd count kept", 16'(retired_count), 16'd9);
        step();
        step();
        check("wd error sticky", 16'(error), 16'd1);

        // Fill the queue while the head stalls at 11.
        idx = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_instr = 16'h5000 + 16'(idx);
            was_ready = in_ready;
            step();
            if (was_ready) idx++;
        end
        check("full accepted", 16'(idx), 16'd5);
        check("full in_ready", 16'(in_ready), 16'd0);
        check("full head", instruction, 16'h5000);
        n = 0;
        while (!(busy && current_state == 2'b00 && instruction == 16'h5001) && n < 40) begin
            in_instr = 16'h5000 + 16'(idx);
            was_ready = in_ready;
            step();
            if (was_ready) idx++;
            n++;
        end
        check("full pop seen", 16'(n < 40), 16'd1);
        check("no push while full", 16'(idx), 16'd5);
        check("ready after pop", 16'(in_ready), 16'd1);
        in_instr = 16'h5005;
        step();
        in_valid = 1'b0;
        for (int k = 1; k < 6; k++) run_retire(16'h5000 + 16'(k));
        check("drain count", 16'(retired_count), 16'h000E);
        step();
        check("drain idle", 16'(busy), 16'd0);

        // Reset mid-execution with two queued words.
        in_valid = 1'b1;
        in_instr = 16'h6000;
        step();
        in_instr = 16'h6001;
        step();
        in_instr = 16'h6002;
        step();
        in_valid = 1'b0;
        wait_cs(2'b10);
        resetn = 1'b0;
        step();
        check_reset_values();
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("post rst busy", 16'(busy), 16'd0);
        check("post rst instr", instruction, 16'h0000);
        check("post rst done", 16'(done), 16'd0);

        // retired_count wraps 255 -> 0.
        for (int i = 0; i < 256; i++) begin
            push_word(16'h7000 + 16'(i));
            run_retire(16'h7000 + 16'(i));
            if (i == 254) check("count 255", 16'(retired_count), 16'h00FF);
        end
        check("count wrap", 16'(retired_count), 16'h0000);
        step();
        check("scoreboard empty", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
